led_pwm_fader: RTL and testbench
================================

// Module: led_pwm_fader
// PURPOSE
//  Downstream stage of blink4: consumes its four on/off LED drives and produces PWM outputs for the board LEDs.
//  Each channel's brightness ramps linearly toward the commanded state, so edges from blink4 appear as smooth fades.
//  All four channels share one PWM counter and one ramp prescaler.
// PARAMETERS
//  PWM_BITS  8  brightness/PWM resolution; MAX = 2**PWM_BITS-1
//  STEP_DIV  4  clk cycles per brightness step (>=1); full ramp = MAX*STEP_DIV cycles
// PORTS
//  clk      in   1  system clock; all logic on rising edge
//  rst      in   1  synchronous, active-high reset
//  led_in   in   4  commanded LED state: bit0=led1 .. bit3=led4 from blink4
//  led_out  out  4  PWM-modulated LED drive, registered
//  fading   out  4  1 while channel level != target (0 or MAX), registered
// BEHAVIOUR
//  Reset (rst=1 at an edge): in_q, pwm_cnt, div_cnt, level[0..3], led_out, fading all 0.
//   Applies mid-ramp too: outputs 0 at the next edge, no partial state kept.
//  Input stage: in_q <= led_in each cycle, so there is 1 cycle of input latency.
//  Prescaler: div_cnt counts 0..STEP_DIV-1 and wraps; tick=1 when div_cnt==STEP_DIV-1.
//   STEP_DIV=1 gives tick=1 every cycle.
//  PWM counter: pwm_cnt counts 0..MAX-1 and wraps to 0; the period is MAX cycles.
//  Per-channel state, derived from level and in_q:
//   OFF     level=0,   in_q=0 -> hold
//   RISING  in_q=1, level<MAX -> level+1 on tick
//   ON      level=MAX, in_q=1 -> hold
//   FALLING in_q=0, level>0   -> level-1 on tick
//   Level saturates at 0 and MAX; it never wraps.
//  Direction reversal mid-ramp: the next tick steps from the current level in the new direction, with no jump.
//  Output: led_out[i] <= (pwm_cnt < level[i]), registered, so it has 1 cycle of latency.
//   level=0 gives a constant 0; level=MAX gives a constant 1; level=L gives exactly L highs per MAX-cycle period.
//  fading[i] <= in_q[i] ? (level[i]!=MAX) : (level[i]!=0).
//  Channels are fully independent; simultaneous changes on several channels are all handled on the same tick.
//  Arithmetic: level is PWM_BITS wide; pwm_cnt is PWM_BITS wide; div_cnt is clog2(STEP_DIV) wide, minimum 1 bit.
//  No combinational path from any input to any output.
// TESTING  (PWM_BITS=4 -> MAX=15, STEP_DIV=2 unless noted; clk period 10)
//  1 Reset: rst=1 for 2 cycles, led_in=4'hF -> led_out=0, fading=0, all levels 0 during reset.
//  2 Full ramp: led_in=4'b0001 held -> fading[0]=1 within 2 cycles.
//    level[0] reaches 15 after 15 ticks (30 cycles, +/-2); then led_out[0] is constant 1 and fading[0]=0.
//  3 Duty: STEP_DIV=64, led_in=4'b0001 until level[0]=5 -> exactly 5 highs per 15-cycle window while the level is stable.
//  4 Reversal: ramp channel 2 to level 8, then led_in[2]=0 -> level goes 8,7,..,0 one step per tick.
//    No 9 is ever seen; at the end fading[2]=0 and led_out[2] is constant 0.
//  5 Mid-ramp reset: rst pulsed while level[1]=7 -> next edge level[1]=0, led_out=0.
//    After release with led_in[1]=1, the ramp restarts from 0.
//  6 Independence: led_in=4'b1010 -> channels 1 and 3 ramp identically; channels 0 and 2 stay level 0 with led_out 0.

Source files
------------

// File: rtl/led_pwm_fader.sv
// Four-channel LED fader: ramps each channel's brightness toward
// its commanded on/off state and drives a shared-counter PWM output.
module led_pwm_fader #(
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] led_in,
  output logic [3:0] led_out,
  output logic [3:0] fading
);

  localparam int DW =
    (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PWM_BITS-1:0] LMAX = '1;
  localparam logic [PWM_BITS-1:0] PWRAP =
    {{(PWM_BITS-1){1'b1}}, 1'b0};
  localparam logic [DW-1:0] DLAST =
    DW'(STEP_DIV - 1);

  typedef enum logic [1:0] {
    OFF,
    RISING,
    ON,
    FALLING
  } mode_t;

  logic [3:0]          in_q;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [DW-1:0]       div_cnt;
  logic                tick;
  logic [PWM_BITS-1:0] level    [4];
  logic [PWM_BITS-1:0] level_nx [4];
  mode_t               mode     [4];
  logic [3:0]          out_nx;
  logic [3:0]          fad_nx;

  assign tick = (div_cnt == DLAST);

  always_comb begin
    out_nx = '0;
    fad_nx = '0;
    for (int i = 0; i < 4; i++) begin
      mode[i]     = OFF;
      level_nx[i] = level[i];
      unique case (1'b1)
        in_q[i] && (level[i] == LMAX):
          mode[i] = ON;
        in_q[i] && (level[i] != LMAX):
          mode[i] = RISING;
        !in_q[i] && (level[i] != '0):
          mode[i] = FALLING;
        default:
          mode[i] = OFF;
      endcase
      // Saturation falls out of the mode decode:
      // ON and OFF never step.
      if (tick) begin
        unique case (mode[i])
          RISING:  level_nx[i] = level[i] + 1'b1;
          FALLING: level_nx[i] = level[i] - 1'b1;
          default: level_nx[i] = level[i];
        endcase
      end
      out_nx[i] = (pwm_cnt < level[i]);
      fad_nx[i] = (mode[i] == RISING) ||
                  (mode[i] == FALLING);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q    <= '0;
      pwm_cnt <= '0;
      div_cnt <= '0;
      led_out <= '0;
      fading  <= '0;
      for (int i = 0; i < 4; i++) begin
        level[i] <= '0;
      end
    end else begin
      in_q    <= led_in;
      led_out <= out_nx;
      fading  <= fad_nx;
      if (tick) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (pwm_cnt == PWRAP) begin
        pwm_cnt <= '0;
      end else begin
        pwm_cnt <= pwm_cnt + 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
        level[i] <= level_nx[i];
      end
    end
  end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Bench for led_pwm_fader: two configs (STEP_DIV 2 and 64)
// share stimulus and are checked against a cycle-count model.
module tb_led_pwm_fader;

  localparam int MAXV = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] led_in;
  logic [3:0] led_out_a, fading_a;
  logic [3:0] led_out_b, fading_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  led_pwm_fader #(.PWM_BITS(4), .STEP_DIV(2)) dut_a (
    .clk(clk), .rst(rst), .led_in(led_in),
    .led_out(led_out_a), .fading(fading_a)
  );

  led_pwm_fader #(.PWM_BITS(4), .STEP_DIV(64)) dut_b (
    .clk(clk), .rst(rst), .led_in(led_in),
    .led_out(led_out_b), .fading(fading_b)
  );

  // Model: k = edges since reset; prescaler and PWM
  // phase are just k modulo their periods.
  int         sdv [2] = '{2, 64};
  int         m_lvl [2][4];
  logic [3:0] m_inq [2];
  int         m_k [2];
  logic [3:0] e_out [2];
  logic [3:0] e_fad [2];
  bit         armed = 1'b0;
  int         ph;
  bit         tk;

  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        m_k[c]   = 0;
        m_inq[c] = '0;
        e_out[c] = '0;
        e_fad[c] = '0;
        for (int i = 0; i < 4; i++) m_lvl[c][i] = 0;
      end else begin
        ph = m_k[c] % MAXV;
        tk = (m_k[c] % sdv[c]) == sdv[c] - 1;
        for (int i = 0; i < 4; i++) begin
          e_out[c][i] = ph < m_lvl[c][i];
          e_fad[c][i] = m_inq[c][i] ?
            (m_lvl[c][i] != MAXV) : (m_lvl[c][i] != 0);
          if (tk) begin
            if (m_inq[c][i])
              m_lvl[c][i] = (m_lvl[c][i] < MAXV) ?
                m_lvl[c][i] + 1 : MAXV;
            else
              m_lvl[c][i] = (m_lvl[c][i] > 0) ?
                m_lvl[c][i] - 1 : 0;
          end
        end
        m_inq[c] = led_in;
        m_k[c]   = m_k[c] + 1;
      end
    end
    if (rst) armed = 1'b1;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 30)
        $display("FAIL %s: got %0h want %0h t=%0t",
                 nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("out_a", led_out_a, e_out[0]);
      chk("fad_a", fading_a, e_fad[0]);
      chk("out_b", led_out_b, e_out[1]);
      chk("fad_b", fading_b, e_fad[1]);
    end
  end

  task automatic wait_lvl(input int c, input int ch,
                          input int v, input int lim,
                          output int n);
    n = 0;
    while (m_lvl[c][ch] != v && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (m_lvl[c][ch] != v)
      chk("wait_timeout", m_lvl[c][ch], v);
  endtask

  initial begin
    int n, hi, mx;
    rst    = 1'b1;
    led_in = 4'hF;
    repeat (2) @(negedge clk);
    chk("rst_out", led_out_a, 0);
    chk("rst_fad", fading_a, 0);
    chk("rst_lvl", m_lvl[0][0] + m_lvl[0][3], 0);

    // full ramp on channel 0
    rst    = 1'b0;
    led_in = 4'b0001;
    repeat (2) @(negedge clk);
    chk("ramp_fad_start", fading_a[0], 1);
    wait_lvl(0, 0, MAXV, 60, n);
    chk("ramp_len", (n + 2 >= 28) && (n + 2 <= 32), 1);
    repeat (2) @(negedge clk);
    hi = 0;
    for (int j = 0; j < MAXV; j++) begin
      @(negedge clk);
      if (led_out_a[0]) hi++;
      chk("full_fad", fading_a[0], 0);
    end
    chk("full_highs", hi, MAXV);

    // reversal on channel 2 at level 8
    led_in = 4'b0101;
    wait_lvl(0, 2, 8, 60, n);
    led_in = 4'b0001;
    mx = 8;
    n  = 0;
    while (m_lvl[0][2] != 0 && n < 40) begin
      @(negedge clk);
      n++;
      if (m_lvl[0][2] > mx) mx = m_lvl[0][2];
    end
    chk("rev_max", mx, 8);
    chk("rev_len", (n >= 15) && (n <= 17), 1);
    repeat (2) @(negedge clk);
    for (int j = 0; j < MAXV; j++) begin
      @(negedge clk);
      chk("rev_off", {fading_a[2], led_out_a[2]}, 0);
    end

    // duty at level 5 on the slow instance
    wait_lvl(1, 0, 5, 800, n);
    repeat (2) @(negedge clk);
    hi = 0;
    for (int j = 0; j < MAXV; j++) begin
      @(negedge clk);
      if (led_out_b[0]) hi++;
    end
    chk("duty_lvl", m_lvl[1][0], 5);
    chk("duty_highs", hi, 5);

    // reset mid-ramp on channel 1
    led_in = 4'b0011;
    wait_lvl(0, 1, 7, 60, n);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_out", {led_out_a, led_out_b}, 0);
    chk("mid_rst_fad", {fading_a, fading_b}, 0);
    chk("mid_rst_lvl", m_lvl[0][1], 0);
    wait_lvl(0, 1, 1, 6, n);
    chk("restart_len", n <= 3, 1);
    chk("restart_fad", fading_a[1], 1);

    // independence
    rst = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    led_in = 4'b1010;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      chk("ind_eq", {led_out_a[1], fading_a[1]},
                    {led_out_a[3], fading_a[3]});
      chk("ind_off", {led_out_a[0], led_out_a[2],
                      fading_a[0], fading_a[2]}, 0);
    end
    chk("ind_lvl", m_lvl[0][1], MAXV);

    // randomized traffic
    for (int j = 0; j < 1500; j++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 9) == 0)
        led_in = 4'($urandom);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
